// File: rtl/rv2t_pipeline_sequencer.sv
// Multi-cycle instruction sequencer for the RV2T core: steps each instruction through
// fetch/decode/execute/memory/mul-div/trap and emits the per-stage strobes.
module rv2t_pipeline_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync_reset,
    input  logic        start,
    input  logic        fetch_ack,
    input  logic        ctl_LOAD,
    input  logic        ctl_STORE,
    input  logic        ctl_MUL_DIV_FUNCT3,
    input  logic        ctl_WFI,
    input  logic        ctl_MRET,
    input  logic        exception_illegal_instruction,
    input  logic        mem_ack,
    input  logic        muldiv_done,
    input  logic        interrupt_pending,
    output logic        fetch_enable,
    output logic        decode_enable,
    output logic        exe_enable,
    output logic        mem_enable,
    output logic        muldiv_start,
    output logic        wb_enable,
    output logic        mret_enable,
    output logic        trap_enable,
    output logic        bus_timeout,
    output logic        instret_pulse,
    output logic [31:0] instret_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_MEM    = 3'd4,
        S_MULDIV = 3'd5,
        S_WFI    = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    // Last MEM cycle index before the access is declared dead.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    logic        r_mem_is_load;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_instret_count;

    state_t      w_next;
    logic        w_mem_entry;
    logic        w_wait_inc;

    always_comb begin
        w_next        = r_state;
        w_mem_entry   = 1'b0;
        w_wait_inc    = 1'b0;
        fetch_enable  = 1'b0;
        decode_enable = 1'b0;
        exe_enable    = 1'b0;
        mem_enable    = 1'b0;
        muldiv_start  = 1'b0;
        wb_enable     = 1'b0;
        mret_enable   = 1'b0;
        trap_enable   = 1'b0;
        bus_timeout   = 1'b0;
        instret_pulse = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                fetch_enable = 1'b1;
                // Interrupts are only taken on an instruction boundary.
                if (interrupt_pending)  w_next = S_TRAP;
                else if (fetch_ack)     w_next = S_DECODE;
            end
            S_DECODE: begin
                decode_enable = 1'b1;
                w_next        = S_EXE;
            end
            S_EXE: begin
                exe_enable = 1'b1;
                if (exception_illegal_instruction) begin
                    w_next = S_TRAP;
                end else if (ctl_WFI) begin
                    instret_pulse = 1'b1;
                    w_next        = S_WFI;
                end else if (ctl_MRET) begin
                    mret_enable   = 1'b1;
                    instret_pulse = 1'b1;
                    w_next        = S_FETCH;
                end else if (ctl_LOAD || ctl_STORE) begin
                    w_mem_entry = 1'b1;
                    w_next      = S_MEM;
                end else if (ctl_MUL_DIV_FUNCT3) begin
                    muldiv_start = 1'b1;
                    w_next       = S_MULDIV;
                end else begin
                    wb_enable     = 1'b1;
                    instret_pulse = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_MEM: begin
                mem_enable = (r_wait_cnt == 8'd0);
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    instret_pulse = 1'b1;
                    wb_enable     = r_mem_is_load;
                    w_next        = S_FETCH;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    bus_timeout = 1'b1;
                    w_next      = S_TRAP;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_MULDIV: begin
                if (muldiv_done) begin
                    wb_enable     = 1'b1;
                    instret_pulse = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_WFI: begin
                if (interrupt_pending) w_next = S_TRAP;
            end
            S_TRAP: begin
                trap_enable = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_mem_is_load   <= 1'b0;
            r_wait_cnt      <= 8'd0;
            r_instret_count <= 32'd0;
        end else if (sync_reset) begin
            r_state         <= S_IDLE;
            r_mem_is_load   <= 1'b0;
            r_wait_cnt      <= 8'd0;
            r_instret_count <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_mem_entry) begin
                r_mem_is_load <= ctl_LOAD;
                r_wait_cnt    <= 8'd0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (instret_pulse) r_instret_count <= r_instret_count + 32'd1;
        end
    end

    assign instret_count = r_instret_count;
    assign state         = r_state;

endmodule

// File: doc/rv2t_pipeline_sequencer.md
# rv2t_pipeline_sequencer

Multi-cycle sequencer for the RV2T core. It steps each instruction through fetch, decode, execute, memory, mul/div and trap, and produces the per-stage enables, including `decode_enable` for the instruction-decode stage. It consumes that stage's control bits during the execute cycle, waits on memory and mul/div completions, and enforces a memory-bus timeout. It also handles WFI/MRET/interrupt/illegal-instruction sequencing and counts retired instructions.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum number of MEM-state cycles without `mem_ack` before a bus timeout. Legal range is 2..255.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- sync_reset  in  1  synchronous reset; forces IDLE and clears the counters.
- start  in  1  leaves IDLE.
- fetch_ack  in  1  instruction word valid from fetch.
- ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_WFI, ctl_MRET  in  1 each  decode control bits, valid in EXE.
- exception_illegal_instruction  in  1  decode exception, valid in EXE.
- mem_ack  in  1  load/store complete.
- muldiv_done  in  1  mul/div result ready.
- interrupt_pending  in  1  enabled interrupt is pending.
- fetch_enable, decode_enable, exe_enable  out  1 each  stage enables.
- mem_enable  out  1  memory request strobe.
- muldiv_start  out  1  mul/div launch strobe.
- wb_enable  out  1  register-file write strobe.
- mret_enable, trap_enable  out  1 each  CSR/PC update strobes.
- bus_timeout  out  1  memory timeout strobe.
- instret_pulse  out  1  instruction retired.
- instret_count  out  32  retired-instruction count; wraps modulo 2^32.
- state  out  3  current state, for debug.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXE=3, MEM=4, MULDIV=5, WFI=6, TRAP=7.
- Registered elements: state, `mem_is_load`, `wait_cnt` (8 bits), `instret_count`.
- All strobes are combinational from the state register and the current inputs. In IDLE every output is 0 except `state`.
- IDLE: `start` → FETCH.
- FETCH: `fetch_enable`=1.
  - `interrupt_pending` → TRAP. This has priority over a simultaneous `fetch_ack`.
  - Otherwise `fetch_ack` → DECODE.
  - Otherwise stay in FETCH.
- DECODE: `decode_enable`=1 for exactly 1 cycle, then → EXE.
- EXE: `exe_enable`=1. The cases below are evaluated in priority order:
  1. `exception_illegal_instruction` → TRAP.
  2. `ctl_WFI` → `instret_pulse`, then → WFI.
  3. `ctl_MRET` → `mret_enable`, `instret_pulse`, then → FETCH.
  4. `ctl_LOAD` or `ctl_STORE` → latch `mem_is_load`=`ctl_LOAD`, clear `wait_cnt`, then → MEM.
  5. `ctl_MUL_DIV_FUNCT3` → `muldiv_start`, then → MULDIV.
  6. Otherwise → `wb_enable`, `instret_pulse`, then → FETCH.
- MEM:
  - `mem_enable`=1 only while `wait_cnt`==0.
  - `mem_ack` → `instret_pulse`, plus `wb_enable`=`mem_is_load`, then → FETCH.
  - Else if `wait_cnt`==MEM_TIMEOUT-1 → `bus_timeout`, then → TRAP.
  - Else `wait_cnt`+1.
- MULDIV: `muldiv_done` → `wb_enable`, `instret_pulse`, then → FETCH. There is no timeout.
- WFI: `interrupt_pending` → TRAP; otherwise stay.
- TRAP: `trap_enable`=1 for 1 cycle, then → FETCH.
- `instret_count` increments on every cycle with `instret_pulse`=1.
- `sync_reset` takes priority over every transition. Next cycle: state=IDLE, `wait_cnt`=0, `instret_count`=0, `mem_is_load`=0.
- Asserting `reset_n` mid-instruction aborts it. No strobe is emitted afterwards until `start`.

## Timing
- Reset values: state=IDLE, `instret_count`=0, `wait_cnt`=0; every strobe 0.
- ALU/LUI/JAL/branch: 3 cycles (FETCH, DECODE, EXE) when `fetch_ack` arrives in the first FETCH cycle.
- Load/store: 4 cycles minimum. Each extra `mem_ack` wait cycle adds 1 cycle.
- Timeout: `bus_timeout` fires in the MEM cycle MEM_TIMEOUT counted from MEM entry. TRAP follows on the next cycle.
- `mem_ack` arriving in that same final cycle wins: the access completes normally and there is no timeout.
- Interrupts are sampled only in FETCH and WFI. An interrupt is never taken mid-instruction.
- `start` outside IDLE is ignored. `mem_ack`/`muldiv_done` outside MEM/MULDIV are ignored.

## Test plan
- ALU op: reset, `start`, `fetch_ack`=1 in the first FETCH cycle, all ctl bits 0 → `decode_enable` 1 cycle, then `wb_enable` and `instret_pulse` in EXE, state back at FETCH; after 3 such instructions, `instret_count`=3.
- Load, `mem_ack` after 2 wait cycles → `mem_enable` only in the first MEM cycle, `wb_enable`=1 on the ack cycle. Repeating as a store → `wb_enable`=0 on the ack cycle, `instret_pulse`=1.
- MEM_TIMEOUT=4, store with no `mem_ack` → `bus_timeout` in the 4th MEM cycle, `trap_enable` next cycle, `instret_count` unchanged. Same test with `mem_ack` in the 4th cycle → no timeout.
- Illegal instruction with `ctl_LOAD`=1 also set → TRAP taken; `mem_enable` never asserted.
- WFI → `instret_pulse` in EXE, 10 cycles held in WFI, then `interrupt_pending` → `trap_enable`, then FETCH. `interrupt_pending` and `fetch_ack` together in FETCH → TRAP.
- `sync_reset` during MULDIV → IDLE next cycle, `instret_count`=0, and a later `muldiv_done` produces no `wb_enable`. Also check that `instret_count` wraps from 0xFFFFFFFF to 0 (preloaded via force).
